// File: rtl/complex_mixer_accum.sv
// Time-interleaved multi-channel complex MAC in 3-multiplier form, integrating acc_len samples per channel.
// Define CMIX_ACC_SATURATE_EN for clamped accumulation with a sticky per-frame ovf flag.
module complex_mixer_accum #(
    parameter  int AWIDTH  = 16,
    parameter  int BWIDTH  = 18,
    parameter  int SIZEOUT = 48,
    parameter  int NCHAN   = 4,
    parameter  int CNTW    = 16,
    localparam int CHW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sync,
    input  logic [CNTW-1:0]           acc_len,
    input  logic                      in_valid,
    input  logic signed [AWIDTH-1:0]  ar,
    input  logic signed [AWIDTH-1:0]  ai,
    input  logic signed [BWIDTH-1:0]  br,
    input  logic signed [BWIDTH-1:0]  bi,
    output logic                      out_valid,
    output logic [CHW-1:0]            out_chan,
    output logic signed [SIZEOUT-1:0] pr,
    output logic signed [SIZEOUT-1:0] pi,
    output logic                      ovf
);
    localparam int STAGES = 5;
    localparam int NACC   = 2 ** CHW;
    localparam int AW1    = AWIDTH + 1;
    localparam int BW1    = BWIDTH + 1;
    localparam int PW     = AWIDTH + BWIDTH + 1;
    localparam int PPW    = PW + 1;

    logic [CHW-1:0]  ch_cnt, ch_cur;
    logic [CNTW-1:0] smp_cnt, smp_cur, len_q, len_eff, len_cur;
    logic            frame_start, first_in, last_in;

    // sync in the same cycle as in_valid makes that sample channel 0, sample 0
    always_comb begin
        len_eff     = (acc_len == '0) ? CNTW'(1) : acc_len;
        ch_cur      = sync ? '0 : ch_cnt;
        smp_cur     = sync ? '0 : smp_cnt;
        frame_start = (ch_cur == '0) && (smp_cur == '0);
        len_cur     = frame_start ? len_eff : len_q;
        first_in    = (smp_cur == '0);
        last_in     = (smp_cur == len_cur - CNTW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt  <= '0;
            smp_cnt <= '0;
            len_q   <= CNTW'(1);
        end else if (in_valid) begin
            if (frame_start) len_q <= len_eff;
            if (ch_cur == CHW'(NCHAN - 1)) begin
                ch_cnt  <= '0;
                smp_cnt <= last_in ? '0 : smp_cur + CNTW'(1);
            end else begin
                ch_cnt  <= ch_cur + CHW'(1);
                smp_cnt <= smp_cur;
            end
        end else if (sync) begin
            ch_cnt  <= '0;
            smp_cnt <= '0;
        end
    end

    logic [STAGES:1]   vld_pipe, last_pipe;
    logic [STAGES-1:1] first_pipe;
    logic [CHW-1:0]    chan_pipe [1:STAGES];

    // sync kills older samples still in flight; the entering sample is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            last_pipe  <= '0;
            first_pipe <= '0;
            for (int s = 1; s <= STAGES; s++) chan_pipe[s] <= '0;
        end else begin
            vld_pipe[1]   <= in_valid;
            last_pipe[1]  <= last_in;
            first_pipe[1] <= first_in;
            chan_pipe[1]  <= ch_cur;
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1] & ~sync;
                last_pipe[s] <= last_pipe[s-1];
                chan_pipe[s] <= chan_pipe[s-1];
            end
            for (int s = 2; s < STAGES; s++) first_pipe[s] <= first_pipe[s-1];
        end
    end

    logic signed [AWIDTH-1:0] ar1, ai1, ar2, ai2;
    logic signed [BWIDTH-1:0] br1, bi1, bi2;
    logic signed [AW1-1:0]    dri2;
    logic signed [BW1-1:0]    bd2, bs2;
    logic signed [PW-1:0]     m1_3, m2_3, m3_3;
    logic signed [PPW-1:0]    pr4, pi4;

    always_ff @(posedge clk) begin
        ar1  <= ar;
        ai1  <= ai;
        br1  <= br;
        bi1  <= bi;
        dri2 <= AW1'(ar1) - AW1'(ai1);
        bd2  <= BW1'(br1) - BW1'(bi1);
        bs2  <= BW1'(br1) + BW1'(bi1);
        ar2  <= ar1;
        ai2  <= ai1;
        bi2  <= bi1;
        m1_3 <= PW'(bd2) * PW'(ar2);
        m2_3 <= PW'(bs2) * PW'(ai2);
        m3_3 <= PW'(dri2) * PW'(bi2);
        pr4  <= PPW'(m1_3) + PPW'(m3_3);
        pi4  <= PPW'(m2_3) + PPW'(m3_3);
    end

    logic signed [SIZEOUT-1:0] acc_re [NACC];
    logic signed [SIZEOUT-1:0] acc_im [NACC];
    logic signed [SIZEOUT-1:0] old_re, old_im, nxt_re, nxt_im;

`ifdef CMIX_ACC_SATURATE_EN
    localparam int SW = ((SIZEOUT > PPW) ? SIZEOUT : PPW) + 1;

    // {clamped, value}: out of range when the bits above the result sign disagree
    function automatic logic [SIZEOUT:0] clamp(input logic signed [SW-1:0] s);
        if (s[SW-1:SIZEOUT-1] == {(SW-SIZEOUT+1){s[SW-1]}}) return {1'b0, s[SIZEOUT-1:0]};
        return {1'b1, s[SW-1], {(SIZEOUT-1){~s[SW-1]}}};
    endfunction

    logic          ovf_re, ovf_im, old_ovf;
    logic [NACC-1:0] ovf_acc;

    always_comb begin
        old_re           = first_pipe[4] ? '0 : acc_re[chan_pipe[4]];
        old_im           = first_pipe[4] ? '0 : acc_im[chan_pipe[4]];
        old_ovf          = first_pipe[4] ? 1'b0 : ovf_acc[chan_pipe[4]];
        {ovf_re, nxt_re} = clamp(SW'(old_re) + SW'(pr4));
        {ovf_im, nxt_im} = clamp(SW'(old_im) + SW'(pi4));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_acc <= '0;
            ovf     <= 1'b0;
        end else begin
            if (vld_pipe[4] && !sync) ovf_acc[chan_pipe[4]] <= old_ovf | ovf_re | ovf_im;
            if (vld_pipe[STAGES] && last_pipe[STAGES]) ovf <= ovf_acc[chan_pipe[STAGES]];
        end
    end
`else
    always_comb begin
        old_re = first_pipe[4] ? '0 : acc_re[chan_pipe[4]];
        old_im = first_pipe[4] ? '0 : acc_im[chan_pipe[4]];
        nxt_re = old_re + SIZEOUT'(pr4);
        nxt_im = old_im + SIZEOUT'(pi4);
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NACC; c++) begin
                acc_re[c] <= '0;
                acc_im[c] <= '0;
            end
        end else if (vld_pipe[4] && !sync) begin
            acc_re[chan_pipe[4]] <= nxt_re;
            acc_im[chan_pipe[4]] <= nxt_im;
        end
    end

    // output register reads the accumulator one cycle after its final update
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_chan  <= '0;
            pr        <= '0;
            pi        <= '0;
        end else begin
            out_valid <= vld_pipe[STAGES] & last_pipe[STAGES];
            if (vld_pipe[STAGES] && last_pipe[STAGES]) begin
                out_chan <= chan_pipe[STAGES];
                pr       <= acc_re[chan_pipe[STAGES]];
                pi       <= acc_im[chan_pipe[STAGES]];
            end
        end
    end
endmodule

// File: tb/tb_complex_mixer_accum.sv
// Directed bench for complex_mixer_accum: four instances (NCHAN 1/2/4, and SIZEOUT=20) share one stimulus bus.
module tb_complex_mixer_accum;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, sync, in_valid;
    logic [15:0]        acc_len;
    logic signed [15:0] ar, ai;
    logic signed [17:0] br, bi;

    logic ov1, ov2, ov4, ov20, f1, f2, f4, f20;
    logic [0:0] c1, c2, c20;
    logic [1:0] c4;
    logic signed [47:0] pr1, pi1, pr2, pi2, pr4, pi4;
    logic signed [19:0] pr20, pi20;

    complex_mixer_accum #(.NCHAN(1)) u1 (.clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len),
        .in_valid(in_valid), .ar(ar), .ai(ai), .br(br), .bi(bi), .out_valid(ov1), .out_chan(c1),
        .pr(pr1), .pi(pi1), .ovf(f1));
    complex_mixer_accum #(.NCHAN(2)) u2 (.clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len),
        .in_valid(in_valid), .ar(ar), .ai(ai), .br(br), .bi(bi), .out_valid(ov2), .out_chan(c2),
        .pr(pr2), .pi(pi2), .ovf(f2));
    complex_mixer_accum #(.NCHAN(4)) u4 (.clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len),
        .in_valid(in_valid), .ar(ar), .ai(ai), .br(br), .bi(bi), .out_valid(ov4), .out_chan(c4),
        .pr(pr4), .pi(pi4), .ovf(f4));
    complex_mixer_accum #(.NCHAN(1), .SIZEOUT(20)) u20 (.clk(clk), .rst(rst), .sync(sync),
        .acc_len(acc_len), .in_valid(in_valid), .ar(ar), .ai(ai), .br(br), .bi(bi),
        .out_valid(ov20), .out_chan(c20), .pr(pr20), .pi(pi20), .ovf(f20));

    typedef struct {
        int     cyc;
        int     ch;
        longint pr;
        longint pi;
        int     ovf;
    } res_t;

    res_t q1[$], q2[$], q4[$], q20[$], tq[$];
    int cyc = 0;
    int n_cmp = 0, n_err = 0;
    int t0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t mk(int c, longint r, longint i, int o);
        res_t x;
        x.cyc = cyc; x.ch = c; x.pr = r; x.pi = i; x.ovf = o;
        return x;
    endfunction

    always @(negedge clk) begin
        if (ov1)  q1.push_back(mk(int'(c1), pr1, pi1, int'(f1)));
        if (ov2)  q2.push_back(mk(int'(c2), pr2, pi2, int'(f2)));
        if (ov4)  q4.push_back(mk(int'(c4), pr4, pi4, int'(f4)));
        if (ov20) q20.push_back(mk(int'(c20), pr20, pi20, int'(f20)));
    end

    // missing results read back as an impossible marker so the checks still run
    function automatic res_t at(int k);
        res_t x;
        x.cyc = -1; x.ch = -1; x.pr = -999999999; x.pi = -999999999; x.ovf = -1;
        if (k < tq.size()) x = tq[k];
        return x;
    endfunction

    task automatic chk(string tag, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic drv(bit v, bit s, int a_r, int a_i, int b_r, int b_i);
        @(negedge clk);
        in_valid = v;
        sync     = s;
        ar       = 16'(a_r);
        ai       = 16'(a_i);
        br       = 18'(b_r);
        bi       = 18'(b_i);
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drv(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; sync = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q1.delete(); q2.delete(); q4.delete(); q20.delete();
    endtask

    int vec [4][6] = '{
        '{1, 1, 1, 1, 0, 2},
        '{-5, 7, 11, -3, -34, 92},
        '{32767, -32768, 131071, -131072, -163839, 0},
        '{-32768, -32768, -131072, -131072, 0, 0}
    };
    longint vec_pi [4] = '{2, 92, -64'sd8589770752, 64'sd8589934592};

    initial begin
        rst = 1'b1; sync = 1'b0; in_valid = 1'b0; acc_len = 16'd1;
        ar = '0; ai = '0; br = '0; bi = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", longint'(ov4), 0);
        chk("rst_pr", pr4, 0);
        chk("rst_pi", pi4, 0);
        chk("rst_chan", longint'(c4), 0);
        chk("rst_ovf", longint'(f20), 0);
        rst = 1'b0;
        q1.delete(); q2.delete(); q4.delete(); q20.delete();

        // single sample, latency
        acc_len = 16'd1;
        drv(1, 0, 100, 0, 3, 4);
        t0 = cyc;
        idle(9);
        tq = q1;
        chk("t1_cnt", tq.size(), 1);
        chk("t1_pr", at(0).pr, 300);
        chk("t1_pi", at(0).pi, 400);
        chk("t1_chan", at(0).ch, 0);
        chk("t1_lat", at(0).cyc - t0, 6);

        // signed corner vectors back to back, then 3-sample accumulation with no bubble
        do_rst();
        acc_len = 16'd1;
        for (int v = 0; v < 4; v++) drv(1, 0, vec[v][0], vec[v][1], vec[v][2], vec[v][3]);
        idle(8);
        tq = q1;
        chk("t2_cnt", tq.size(), 4);
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("t2_pr%0d", v), at(v).pr, longint'(vec[v][4]));
            chk($sformatf("t2_pi%0d", v), at(v).pi, vec_pi[v]);
        end
        q1.delete();
        acc_len = 16'd3;
        drv(1, 0, 1, 1, 1, 1);
        drv(1, 0, -5, 7, 11, -3);
        drv(1, 0, -5, 7, 11, -3);
        idle(8);
        tq = q1;
        chk("t2_acc_cnt", tq.size(), 1);
        chk("t2_acc_pr", at(0).pr, -68);
        chk("t2_acc_pi", at(0).pi, 186);

        // two channels with gaps, two frames
        do_rst();
        acc_len = 16'd4;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < 8; k++) begin
                if (k % 2 == 0) drv(1, 0, 1000, 0, 1, 0);
                else            drv(1, 0, 0, 1000, 0, 1);
                idle(int'($urandom_range(2)));
            end
        idle(10);
        tq = q2;
        chk("t3_cnt", tq.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t3_chan%0d", j), at(j).ch, j % 2);
            chk($sformatf("t3_pr%0d", j), at(j).pr, (j % 2 == 1) ? -4000 : 4000);
            chk($sformatf("t3_pi%0d", j), at(j).pi, 0);
        end

        // narrow accumulator overflow, ovf cleared by the next frame
        do_rst();
        acc_len = 16'd1;
        drv(1, 0, -32768, 0, -131072, 0);
        drv(1, 0, 1, 0, 1, 0);
        idle(8);
        tq = q20;
        chk("t4_cnt", tq.size(), 2);
`ifdef CMIX_ACC_SATURATE_EN
        chk("t4_pr", at(0).pr, 524287);
        chk("t4_ovf", at(0).ovf, 1);
`else
        chk("t4_pr", at(0).pr, 0);
        chk("t4_ovf", at(0).ovf, 0);
`endif
        chk("t4_pi", at(0).pi, 0);
        chk("t4_pr_next", at(1).pr, 1);
        chk("t4_ovf_next", at(1).ovf, 0);

        // sync after 10 samples; acc_len change mid-frame applies to the following frame
        do_rst();
        acc_len = 16'd8;
        for (int k = 0; k < 10; k++) drv(1, 0, 1, 0, 1, 0);
        acc_len = 16'd2;
        for (int k = 0; k < 8; k++) begin
            drv(1, k == 0, (k % 4) + 1, 0, 1, 0);
            if (k == 1) acc_len = 16'd3;
        end
        for (int k = 0; k < 12; k++) drv(1, 0, 10, 0, 1, 0);
        idle(10);
        tq = q4;
        chk("t5_cnt", tq.size(), 8);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t5_chan%0d", j), at(j).ch, j % 4);
            chk($sformatf("t5_pr%0d", j), at(j).pr, (j < 4) ? 2 * (j + 1) : 30);
        end
        chk("t5_pi", at(5).pi, 0);

        // hold after a result, reset mid-frame, then acc_len=0 behaving as 1
        do_rst();
        acc_len = 16'd1;
        for (int k = 0; k < 4; k++) drv(1, 0, 5, 0, 1, 0);
        idle(8);
        chk("t6_hold_pr", pr4, 5);
        chk("t6_hold_chan", longint'(c4), 3);
        chk("t6_hold_valid", longint'(ov4), 0);
        q4.delete();
        acc_len = 16'd8;
        for (int k = 0; k < 29; k++) drv(1, 0, 1, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_pr", pr4, 0);
        chk("t6_rst_pi", pi4, 0);
        chk("t6_rst_chan", longint'(c4), 0);
        chk("t6_rst_valid", longint'(ov4), 0);
        idle(10);
        chk("t6_no_stale", q4.size(), 0);
        acc_len = 16'd0;
        for (int k = 0; k < 4; k++) drv(1, 0, k + 2, 0, 1, 0);
        idle(8);
        tq = q4;
        chk("t6_len0_cnt", tq.size(), 4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t6_len0_chan%0d", j), at(j).ch, j);
            chk($sformatf("t6_len0_pr%0d", j), at(j).pr, j + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
